// File: rtl/eight_dot_product_multiply_ctrl.sv
// 8-lane pipelined dot-product engine: multiply, 3-level adder tree, beat accumulator.
// Optional build macro DOT8_SAT_ACC_EN selects saturating arithmetic instead of wrapping.
module eight_dot_product_multiply_ctrl #(
   parameter int unsigned NOE = 16,
   parameter int unsigned EW  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [8*EW-1:0] first_row_input,
   input  logic [8*EW-1:0] second_row_input,
   output logic [EW-1:0]   result,
   output logic            finish,
   input  logic            outsider_read_now
);

   localparam int unsigned LANES  = 8;
   localparam int unsigned CHUNKS = (NOE + LANES - 1) / LANES;
   localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

`ifdef DOT8_SAT_ACC_EN
   localparam logic [EW-1:0] SAT_MAX = {1'b0, {(EW-1){1'b1}}};
   localparam logic [EW-1:0] SAT_MIN = {1'b1, {(EW-1){1'b0}}};

   // Full-width signed product, clamped when the upper half is not a sign extension.
   function automatic logic [EW-1:0] mul_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
      logic [2*EW-1:0] p;
      p = {{EW{a[EW-1]}}, a} * {{EW{b[EW-1]}}, b};
      if ((&p[2*EW-1:EW-1]) || (~|p[2*EW-1:EW-1])) return p[EW-1:0];
      return p[2*EW-1] ? SAT_MIN : SAT_MAX;
   endfunction

   function automatic logic [EW-1:0] add_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
      logic [EW:0] s;
      s = {a[EW-1], a} + {b[EW-1], b};
      if (s[EW] == s[EW-1]) return s[EW-1:0];
      return s[EW] ? SAT_MIN : SAT_MAX;
   endfunction
`else
   // Low EW bits of the product are identical for signed and unsigned operands.
   function automatic logic [EW-1:0] mul_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
      return a * b;
   endfunction

   function automatic logic [EW-1:0] add_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
      return a + b;
   endfunction
`endif

   logic [EW-1:0] a_q [LANES];
   logic [EW-1:0] a_d [LANES];
   logic [EW-1:0] b_q [LANES];
   logic [EW-1:0] b_d [LANES];
   logic [EW-1:0] prod_q [LANES];
   logic [EW-1:0] prod_d [LANES];
   logic [EW-1:0] s2_q [4];
   logic [EW-1:0] s2_d [4];
   logic [EW-1:0] s3_q [2];
   logic [EW-1:0] s3_d [2];
   logic [EW-1:0] beat_q, beat_d;
   logic [EW-1:0] acc_q, acc_d;
   logic [EW-1:0] result_q, result_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic          finish_q, finish_d;

   // Datapath stages load every cycle; the valid chain qualifies what reaches the accumulator.
   always_comb begin
      v0_d = outsider_read_now;
      v1_d = v0_q;
      v2_d = v1_q;
      v3_d = v2_q;
      v4_d = v3_q;
      for (int i = 0; i < LANES; i++) begin
         a_d[i]    = first_row_input[EW*i +: EW];
         b_d[i]    = second_row_input[EW*i +: EW];
         prod_d[i] = mul_f(a_q[i], b_q[i]);
      end
      for (int i = 0; i < 4; i++) s2_d[i] = add_f(prod_q[2*i], prod_q[2*i+1]);
      for (int i = 0; i < 2; i++) s3_d[i] = add_f(s2_q[2*i], s2_q[2*i+1]);
      beat_d = add_f(s3_q[0], s3_q[1]);

      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      finish_d = 1'b0;
      if (v4_q) begin
         acc_d = add_f((cnt_q == '0) ? '0 : acc_q, beat_q);
         if (cnt_q == CW'(CHUNKS - 1)) begin
            cnt_d    = '0;
            result_d = acc_d;
            finish_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) begin
            a_q[i]    <= '0;
            b_q[i]    <= '0;
            prod_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) s2_q[i] <= '0;
         for (int i = 0; i < 2; i++) s3_q[i] <= '0;
         beat_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         v0_q     <= 1'b0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         v4_q     <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         beat_q   <= beat_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         v0_q     <= v0_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         v3_q     <= v3_d;
         v4_q     <= v4_d;
         finish_q <= finish_d;
      end
   end

   assign result = result_q;
   assign finish = finish_q;

endmodule

// File: tb/tb_eight_dot_product_multiply_ctrl.sv
// Scoreboard bench for eight_dot_product_multiply_ctrl (NOE=16, two beats per result).
module tb_eight_dot_product_multiply_ctrl;

   localparam int unsigned EW  = 32;
   localparam int unsigned NOE = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            rd;
   logic [8*EW-1:0] a_in, b_in;
   logic [EW-1:0]   result;
   logic            finish;

   typedef struct {
      logic [EW-1:0] val;
      int            cyc;
      string         name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   eight_dot_product_multiply_ctrl #(.NOE(NOE), .EW(EW)) dut (
      .clk               (clk),
      .reset             (reset),
      .first_row_input   (a_in),
      .second_row_input  (b_in),
      .result            (result),
      .finish            (finish),
      .outsider_read_now (rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every finish pulse must match the oldest pending result, value and arrival cycle.
   always @(negedge clk) begin
      if (reset === 1'b1 && finish !== 1'b0) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_finish: finish=%b at cycle %0d, required 0 (no result pending)", finish, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (result !== e.val) begin
               n_fail++;
               $display("FAIL %s_value: result=%h, required %h", e.name, result, e.val);
            end
            n_checks++;
            if (cyc !== e.cyc) begin
               n_fail++;
               $display("FAIL %s_latency: finish at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [8*EW-1:0] splat(input logic [EW-1:0] v);
      logic [8*EW-1:0] r;
      for (int i = 0; i < 8; i++) r[EW*i +: EW] = v;
      return r;
   endfunction

   task automatic send_beat(input logic [8*EW-1:0] a, input logic [8*EW-1:0] b, output int acc_cyc);
      a_in    = a;
      b_in    = b;
      rd      = 1'b1;
      acc_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rd = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string name, input logic [EW-1:0] val, input int acc_cyc);
      exp_t e;
      e.val  = val;
      e.cyc  = acc_cyc + 6;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      rd = 1'b0;
      while (q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d results still pending, required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 8; i++) begin
            a_in[EW*i +: EW] = EW'($urandom());
            b_in[EW*i +: EW] = EW'($urandom());
         end
         rd = 1'($urandom_range(1, 0));
         @(negedge clk);
         n_checks++;
         if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: result=%h, required 0", result);
         end
         n_checks++;
         if (finish !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_finish: finish=%b, required 0", finish);
         end
      end
      rd    = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_checks++;
         if (finish !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: finish=%b result=%h, required 0 and 0", finish, result);
         end
      end
   endtask

   task automatic test_ones();
      int c;
      send_beat(splat(EW'(1)), splat(EW'(1)), c);
      send_beat(splat(EW'(1)), splat(EW'(1)), c);
      push("ones", EW'(16), c);
      wait_drain("ones");
      idle(3);
   endtask

   task automatic test_ramp_gap();
      logic [8*EW-1:0] a;
      int c;
      for (int i = 0; i < 8; i++) a[EW*i +: EW] = EW'(i + 1);
      send_beat(a, splat(EW'(2)), c);
      idle(3);
      send_beat(a, splat(EW'(2)), c);
      push("ramp", EW'(144), c);
      wait_drain("ramp");
      idle(2);
   endtask

   task automatic test_back_to_back_negative();
      int c;
      for (int k = 0; k < 4; k++) begin
         send_beat(splat(EW'(-3)), splat(EW'(5)), c);
         if (k % 2 == 1) push("neg", 32'hFFFF_FF10, c);
      end
      wait_drain("neg");
      idle(2);
   endtask

   task automatic test_reset_midstream();
      int c;
      send_beat(splat(EW'(7)), splat(EW'(3)), c);
      idle(2);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (finish !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: finish=%b result=%h, required 0 and 0", finish, result);
         end
      end
      reset = 1'b1;
      idle(2);
      send_beat(splat(EW'(1)), splat(EW'(1)), c);
      send_beat(splat(EW'(1)), splat(EW'(1)), c);
      push("midreset", EW'(16), c);
      wait_drain("midreset");
      idle(2);
   endtask

   task automatic test_overflow();
      int c;
      logic [EW-1:0] exp_v;
`ifdef DOT8_SAT_ACC_EN
      exp_v = 32'h7FFF_FFFF;
`else
      exp_v = '0;
`endif
      send_beat(splat(32'h0001_0000), splat(32'h0001_0000), c);
      send_beat(splat(32'h0001_0000), splat(32'h0001_0000), c);
      push("overflow", exp_v, c);
      wait_drain("overflow");
      idle(2);
   endtask

   // Small operands keep every intermediate in range, so wrap and saturate builds agree.
   task automatic test_random();
      logic [8*EW-1:0] a, b;
      longint sum;
      int c, va, vb;
      for (int d = 0; d < 6; d++) begin
         sum = 0;
         for (int beat = 0; beat < 2; beat++) begin
            for (int i = 0; i < 8; i++) begin
               va = int'($urandom_range(2000, 0)) - 1000;
               vb = int'($urandom_range(2000, 0)) - 1000;
               a[EW*i +: EW] = EW'(va);
               b[EW*i +: EW] = EW'(vb);
               sum += longint'(va) * longint'(vb);
            end
            send_beat(a, b, c);
            if (beat == 1) push("random", EW'(sum), c);
            idle(int'($urandom_range(2, 0)));
         end
      end
      wait_drain("random");
   endtask

   initial begin
      reset = 1'b0;
      rd    = 1'b0;
      a_in  = '0;
      b_in  = '0;
      @(negedge clk);
      test_reset();
      test_ones();
      test_ramp_gap();
      test_back_to_back_negative();
      test_reset_midstream();
      test_overflow();
      test_random();
      idle(10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
